reset_sequencer: RTL

//  Generalised successor to the single-output reset stretcher. Releases CHANNELS active-high

---
 rtl/reset_seq_pkg.sv | 31 +++
 rtl/reset_sequencer_if.sv | 36 +++
 rtl/rs_countdown.sv | 34 +++
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer.
// The optional ack handshake is selected by the RESET_SEQ_ACK_EN macro in the top.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StWaitAck,
    StDone,
    StFault
  } state_e;

  localparam int unsigned FaultChWidth = 4;

  function automatic int unsigned max_of3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned step,
                                            input int unsigned timeout);
    return $clog2(max_of3(hold, step, timeout) + 1);
  endfunction

  function automatic int unsigned stage_width(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake and status bundle between the reset sequencer and its consumers.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned CHANNELS = 4
) ();

  logic                    soft_req;
  logic [CHANNELS-1:0]     stage_ack;
  logic [CHANNELS-1:0]     reset_out;
  logic                    busy;
  logic                    done;
  logic                    fault;
  logic [FaultChWidth-1:0] fault_ch;

  modport master (
    output soft_req,
    output stage_ack,
    input  reset_out,
    input  busy,
    input  done,
    input  fault,
    input  fault_ch
  );

  modport slave (
    input  soft_req,
    input  stage_ack,
    output reset_out,
    output busy,
    output done,
    output fault,
    output fault_ch
  );

endinterface

// File: rtl/rs_countdown.sv
// Phase counter shared by hold, step and timeout: counts up from 0 and saturates at limit.
module rs_countdown #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] limit,
  output logic             hit
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !hit) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == limit);

endmodule

// File: rtl/reset_sequencer.sv
// Releases CHANNELS resets in ascending order after a hold period, one per step.
// Define RESET_SEQ_ACK_EN to build the per-channel ack wait and timeout fault.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic              clock,
  input logic              resetn,
  reset_sequencer_if.slave bus
);

  localparam int unsigned CntW   = cnt_width(HOLD_CYCLES, STEP_CYCLES, TIMEOUT);
  localparam int unsigned StageW = stage_width(CHANNELS);
  localparam logic [StageW-1:0] LastStage = StageW'(CHANNELS - 1);

  state_e                  state_q;
  logic [StageW-1:0]       stage_q;
  logic [CHANNELS-1:0]     reset_out_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    fault_q;
  logic [FaultChWidth-1:0] fault_ch_q;

  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    cnt_hit;
  logic [CntW-1:0]         cnt_limit;
  logic                    last_stage;
  logic [CHANNELS-1:0]     stage_sel;

  assign last_stage = (stage_q == LastStage);
  assign stage_sel  = CHANNELS'(1) << stage_q;

`ifdef RESET_SEQ_ACK_EN
  logic ack_seen;
  // Only the current stage's ack bit matters; higher and lower bits are don't-care.
  assign ack_seen = |(bus.stage_ack & stage_sel);
`else
  logic unused_stage_ack;
  assign unused_stage_ack = ^bus.stage_ack;
`endif

  always_comb begin
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_limit = '0;
    unique case (state_q)
      StHold:    cnt_limit = CntW'(HOLD_CYCLES - 1);
      StRelease: cnt_limit = CntW'(STEP_CYCLES - 1);
      StWaitAck: cnt_limit = CntW'(TIMEOUT - 1);
      default:   cnt_limit = '0;
    endcase
    if (bus.soft_req || (state_q == StDone) || (state_q == StFault)) begin
      cnt_clr = 1'b1;
`ifdef RESET_SEQ_ACK_EN
    end else if ((state_q == StWaitAck) && ack_seen) begin
      cnt_clr = 1'b1;
`endif
    end else if (cnt_hit) begin
      cnt_clr = 1'b1;
    end else begin
      cnt_en = 1'b1;
    end
  end

  rs_countdown #(
    .Width (CntW)
  ) u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .limit  (cnt_limit),
    .hit    (cnt_hit)
  );

  always_ff @(posedge clock) begin
    if (!resetn || bus.soft_req) begin
      state_q     <= StHold;
      stage_q     <= '0;
      reset_out_q <= '1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fault_ch_q  <= '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_hit) begin
            state_q <= StRelease;
            stage_q <= '0;
          end
        end
        StRelease: begin
          reset_out_q <= reset_out_q & ~stage_sel;
          if (cnt_hit) begin
`ifdef RESET_SEQ_ACK_EN
            state_q <= StWaitAck;
`else
            if (last_stage) begin
              state_q <= StDone;
            end else begin
              stage_q <= stage_q + StageW'(1);
            end
`endif
          end
        end
`ifdef RESET_SEQ_ACK_EN
        StWaitAck: begin
          // Ack wins over a timeout landing on the same cycle.
          if (ack_seen) begin
            if (last_stage) begin
              state_q <= StDone;
            end else begin
              stage_q <= stage_q + StageW'(1);
              state_q <= StRelease;
            end
          end else if (cnt_hit) begin
            state_q    <= StFault;
            fault_q    <= 1'b1;
            fault_ch_q <= FaultChWidth'(stage_q);
          end
        end
`endif
        StDone: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.reset_out = reset_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef RESET_SEQ_ACK_EN
  assign bus.fault     = fault_q;
  assign bus.fault_ch  = fault_ch_q;
`else
  logic unused_fault;
  assign unused_fault  = fault_q ^ (^fault_ch_q);
  assign bus.fault     = 1'b0;
  assign bus.fault_ch  = '0;
`endif

endmodule
